// File: rtl/rubik_colors_pkg.sv
// Shared sticker colour codes and their display palette, used by the
// classifier, the face streamer and the display overlay.
package rubik_colors_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] COLOR_WHITE  = 3'd0;
  localparam logic [CODE_W-1:0] COLOR_ORANGE = 3'd1;
  localparam logic [CODE_W-1:0] COLOR_GREEN  = 3'd2;
  localparam logic [CODE_W-1:0] COLOR_RED    = 3'd3;
  localparam logic [CODE_W-1:0] COLOR_BLUE   = 3'd4;
  localparam logic [CODE_W-1:0] COLOR_YELLOW = 3'd5;

  localparam logic [23:0] RGB_WHITE  = 24'hFF_FF_FF;
  localparam logic [23:0] RGB_ORANGE = 24'hFF_80_00;
  localparam logic [23:0] RGB_GREEN  = 24'h00_C0_00;
  localparam logic [23:0] RGB_RED    = 24'hC0_00_00;
  localparam logic [23:0] RGB_BLUE   = 24'h00_00_FF;
  localparam logic [23:0] RGB_YELLOW = 24'hFF_FF_00;
  localparam logic [23:0] RGB_BLACK  = 24'h00_00_00;

endpackage

// File: rtl/color_palette.sv
// Combinational sticker-code to RGB lookup; unused codes map to black and
// raise bad.
module color_palette
  import rubik_colors_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [23:0]       rgb,
  output logic              bad
);

  always_comb begin
    rgb = RGB_BLACK;
    bad = 1'b0;
    case (code)
      COLOR_WHITE:  rgb = RGB_WHITE;
      COLOR_ORANGE: rgb = RGB_ORANGE;
      COLOR_GREEN:  rgb = RGB_GREEN;
      COLOR_RED:    rgb = RGB_RED;
      COLOR_BLUE:   rgb = RGB_BLUE;
      COLOR_YELLOW: rgb = RGB_YELLOW;
      default:      bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/face_color_streamer.sv
// Accepts one face of sticker codes and streams one registered RGB pixel per
// sticker, in index order, with backpressure and an end-of-face done pulse.
module face_color_streamer
  import rubik_colors_pkg::*;
#(
  parameter int STICKERS = 9,
  parameter int IDX_W    = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       face_valid,
  output logic                       face_ready,
  input  logic [CODE_W*STICKERS-1:0] face_codes,
  output logic                       pixel_valid,
  input  logic                       pixel_ready,
  output logic [7:0]                 pixel_red,
  output logic [7:0]                 pixel_green,
  output logic [7:0]                 pixel_blue,
  output logic [IDX_W-1:0]           pixel_index,
  output logic                       pixel_last,
  output logic                       pixel_bad,
  output logic                       face_done,
  output logic                       face_error
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  logic [0:0]                 state;
  logic [CODE_W*STICKERS-1:0] face_q;
  logic                       err_acc;
  logic [CODE_W-1:0]          next_code;
  logic [IDX_W-1:0]           next_index;
  logic [23:0]                next_rgb;
  logic                       next_bad;

  assign face_ready = (state == IDLE);
  assign next_index = pixel_index + IDX_W'(1);

  // In IDLE the first pixel comes straight from the incoming face, since the
  // latched copy is only written on the same edge.
  always_comb begin
    next_code = '0;
    if (state == IDLE)
      next_code = face_codes[CODE_W-1:0];
    else if (!pixel_last)
      next_code = face_q[CODE_W*(int'(pixel_index) + 1) +: CODE_W];
  end

  color_palette u_palette (
    .code (next_code),
    .rgb  (next_rgb),
    .bad  (next_bad)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      face_q      <= '0;
      err_acc     <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_red   <= '0;
      pixel_green <= '0;
      pixel_blue  <= '0;
      pixel_index <= '0;
      pixel_last  <= 1'b0;
      pixel_bad   <= 1'b0;
      face_done   <= 1'b0;
      face_error  <= 1'b0;
    end else begin
      face_done  <= 1'b0;
      face_error <= 1'b0;
      case (state)
        IDLE: begin
          if (face_valid) begin
            state       <= STREAM;
            face_q      <= face_codes;
            err_acc     <= 1'b0;
            pixel_valid <= 1'b1;
            pixel_index <= '0;
            pixel_last  <= (STICKERS == 1);
            {pixel_red, pixel_green, pixel_blue} <= next_rgb;
            pixel_bad   <= next_bad;
          end
        end
        default: begin
          // Everything below is gated by the handshake, so a stall freezes it.
          if (pixel_ready) begin
            if (pixel_last) begin
              state       <= IDLE;
              pixel_valid <= 1'b0;
              face_done   <= 1'b1;
              face_error  <= err_acc | pixel_bad;
            end else begin
              err_acc     <= err_acc | pixel_bad;
              pixel_index <= next_index;
              pixel_last  <= (next_index == IDX_W'(STICKERS - 1));
              {pixel_red, pixel_green, pixel_blue} <= next_rgb;
              pixel_bad   <= next_bad;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/face_color_streamer.md
Name: face_color_streamer

Overview:
- Inverse of the RGB-to-code classifier: takes one cube face of sticker colour codes and streams out one 8-bit-per-channel RGB triple per sticker, in index order.
- Sits between the cube-state store/solver and the display/overlay path; feeds the VGA face preview and sensor-calibration readback.
- Accepts a face with a valid/ready handshake; emits pixels with a valid/ready handshake that supports backpressure.

Parameters:
- STICKERS, 9, stickers per face; legal range 1..16.
- IDX_W, 4, width of pixel_index; must satisfy 2^IDX_W >= STICKERS.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- face_valid  in  1  face_codes is valid.
- face_ready  out  1  block can accept a face.
- face_codes  in  3*STICKERS  packed codes; sticker i occupies bits [3i+2:3i].
- pixel_valid  out  1  pixel_* outputs hold a valid pixel.
- pixel_ready  in  1  consumer accepts the pixel.
- pixel_red  out  8  red channel.
- pixel_green  out  8  green channel.
- pixel_blue  out  8  blue channel.
- pixel_index  out  IDX_W  sticker index of the current pixel.
- pixel_last  out  1  current pixel is index STICKERS-1.
- pixel_bad  out  1  current sticker code was 6 or 7.
- face_done  out  1  one-cycle pulse after the last pixel is accepted.
- face_error  out  1  valid only with face_done; set if any sticker in the face was bad.

Behaviour:
- Colour codes: W=0, O=1, G=2, Red=3, Blue=4, Y=5.
- Palette as R,G,B hex: W FF,FF,FF; O FF,80,00; G 00,C0,00; Red C0,00,00; Blue 00,00,FF; Y FF,FF,00; codes 6 and 7 produce 00,00,00 with pixel_bad=1.
- Reset values (asynchronous on reset_n low):
  - state=IDLE, face_ready=1.
  - pixel_valid=0, pixel_red/green/blue=0, pixel_index=0, pixel_last=0, pixel_bad=0.
  - face_done=0, face_error=0, latched face and error accumulator cleared.
- IDLE:
  - face_ready=1.
  - On face_valid&&face_ready at edge N: latch face_codes, clear the error accumulator, enter STREAM.
  - The pixel for index 0 is registered at edge N, so pixel_valid=1 in cycle N+1 (latency 1).
- STREAM:
  - face_ready=0; all pixel outputs are registered.
  - Outputs must hold stable while pixel_valid&&!pixel_ready (no output change under stall).
  - On a pixel_valid&&pixel_ready handshake with index < STICKERS-1: OR pixel_bad into the accumulator, then load the next index. Next pixel appears the following cycle, with no bubble.
  - On a handshake with pixel_last=1: set pixel_valid=0 and go to IDLE.
  - face_done=1 and face_error=(accumulator | final pixel_bad) in the next cycle only.
- face_done cycle:
  - face_ready=1 in the same cycle, so a new face can be accepted then.
  - A back-to-back face gives a one-cycle pixel_valid gap between faces.
- face_codes changes while not handshaking have no effect.
- STICKERS=1: the first pixel has pixel_last=1, and face_done follows its acceptance.
- pixel_index never exceeds STICKERS-1 and never wraps.
- Reset mid-stream aborts immediately: no face_done, and the remaining pixels are discarded.
- face_valid during STREAM is ignored, since face_ready=0.

Decomposition:
- Shared package (rubik_colors_pkg) holds:
  - colour code constants W/O/G/Red/Blue/Y, 3 bits wide;
  - palette localparams, 24 bits per colour;
  - CODE_W=3.
- The colour-to-RGB classifier uses the same codes.
- One sub-module is natural: color_palette, a purely combinational 3-bit code to 24-bit RGB map plus bad flag. It is reused by the display overlay.
- face_color_streamer holds the handshake FSM, index counter and output registers.

Test Plan:
- Face codes 0,1,2,3,4,5,0,1,2 with pixel_ready held 1:
  - face_valid accepted at edge 0;
  - pixels at cycles 1..9 with RGB FFFFFF, FF8000, 00C000, C00000, 0000FF, FFFF00, FFFFFF, FF8000, 00C000;
  - pixel_last only on index 8;
  - face_done=1 with face_error=0 at cycle 10.
- Same face, pixel_ready low for 3 cycles at index 4: pixel outputs and index stay frozen at 0000FF / 4, then resume; face_done is delayed by exactly 3 cycles.
- Codes with index 2=6 and index 7=7: those pixels are 000000 with pixel_bad=1, and face_error=1 at face_done.
- Second face presented with face_valid held high: accepted in the face_done cycle, and index 0 of the new face appears one cycle later.
- reset_n pulsed low during index 5: all outputs return to reset values immediately, no face_done follows, and face_ready=1 after release.
- face_valid toggled during STREAM with different codes: ignored, and the streamed pixels match the latched face.
